mcycle_scheduler: RTL and testbench
===================================

MCYCLE_SCHEDULER -- requirements
Module: mcycle_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ReqValid  input  1  decode presents a MUL/DIV request.
REQ-005 SHALL have port ReqOp  input  1  0 = multiply, 1 = divide.
REQ-006 SHALL have ports ReqOp1, ReqOp2  input  WIDTH  multiplicand/dividend, multiplier/divisor.
REQ-007 SHALL have port ReqWA3  input  4  destination register.
REQ-008 SHALL have port ReqReady  output  1  request accepted this cycle when ReqValid && ReqReady.
REQ-009 SHALL have ports RA1, RA2, RA3  input  4  source registers of instruction in decode.
REQ-010 SHALL have port HazardStall  output  1  decode source matches pending destination.
REQ-011 SHALL have port Flush  input  1  cancel pending operation's writeback.
REQ-012 SHALL have ports Start, MCycleOp  output  1  command to multi-cycle unit.
REQ-013 SHALL have ports Operand1, Operand2  output  WIDTH  registered operands to unit.
REQ-014 SHALL have ports Busy, Done  input  1  unit status; Result  input  WIDTH.
REQ-015 SHALL have port AluWE  input  1  ALU writeback owns register-file port this cycle.
REQ-016 SHALL have ports WBValid  output  1, WBAddr  output  4, WBData  output  WIDTH  multi-cycle writeback.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, HOLD, encoded in a registered state variable.
REQ-018 IDLE: ReqReady=1; on ReqValid SHALL latch ReqOp/Op1/Op2/WA3, set Pending, go ISSUE.
REQ-019 IDLE accept with ReqOp=1 and ReqOp2=0 SHALL bypass the unit: load result buffer with all-ones, go HOLD next cycle.
REQ-020 ISSUE: Start=1 for exactly one cycle with latched MCycleOp/Operand1/Operand2; then WAIT.
REQ-021 WAIT: on Done SHALL capture Result into buffer; if AluWE=0 that cycle, go IDLE with WBValid=1 next cycle; else go HOLD.
REQ-022 HOLD: WBValid=1 whenever AluWE=0; after that cycle go IDLE; remain HOLD while AluWE=1.
REQ-023 WBValid SHALL be registered, 1-cycle pulse, never asserted in a cycle where AluWE=1.
REQ-024 WBAddr/WBData SHALL equal latched WA3 and buffered result while WBValid=1.
REQ-025 ReqReady SHALL be 0 in ISSUE, WAIT, HOLD; requests are not queued.
REQ-026 HazardStall SHALL be combinational: Pending && (RA1==WA3 || RA2==WA3 || RA3==WA3).
REQ-027 Pending SHALL clear in the cycle WBValid is asserted or on Flush.
REQ-028 Flush in ISSUE/WAIT SHALL set Discard; Start still issued if in ISSUE; Done then returns to IDLE with no WBValid.
REQ-029 Flush in HOLD SHALL return to IDLE without WBValid; Flush in IDLE SHALL block that cycle's accept.
REQ-030 Done outside WAIT SHALL be ignored; Busy is monitored only for assertion (Start while Busy=1 never issued: ISSUE waits while Busy=1).
REQ-031 Multiply latency request-to-WBValid SHALL be unit latency + 3 cycles with AluWE=0.

Reset
REQ-032 Reset SHALL force IDLE, Pending=0, Discard=0, Start=0, WBValid=0, Operand1/2=0, WBAddr=0, WBData=0.
REQ-033 Reset mid-operation SHALL abandon the op; a later Done before the next accept SHALL be ignored.

Verification
REQ-034 MUL 7*6, WA3=4, AluWE=0 -> one Start pulse, WBValid with WBAddr=4, WBData=42.
REQ-035 DIV 100/0, WA3=2 -> no Start, WBValid with WBData=0xFFFFFFFF two cycles after accept.
REQ-036 DIV 100/7 with AluWE=1 at Done for 3 cycles -> HOLD 3 cycles, WBValid on 4th, WBData=14.
REQ-037 Pending WA3=5, RA2=5 -> HazardStall=1 until WBValid cycle, then 0.
REQ-038 Flush during WAIT -> Done produces no WBValid, ReqReady=1 next cycle, HazardStall=0.
REQ-039 Reset asserted in WAIT, stray Done next cycle -> state IDLE, WBValid stays 0.

Source files
------------

// File: rtl/mcycle_scheduler.sv
// mcycle_scheduler: issues one MUL/DIV request at a time to a multi-cycle
// unit, tracks its destination register for decode hazard detection, and
// arbitrates the unit's result onto the shared register-file write port.
//
// Ports:
//   CLK, Reset                 clock, synchronous active-high reset
//   ReqValid/ReqReady          request handshake from decode
//   ReqOp                      0 = multiply, 1 = divide
//   ReqOp1, ReqOp2, ReqWA3     operands and destination register
//   RA1, RA2, RA3              decode source registers (hazard compare)
//   HazardStall                combinational: decode source hits pending dest
//   Flush                      cancel the pending operation's writeback
//   Start, MCycleOp            one-cycle command to the multi-cycle unit
//   Operand1, Operand2         registered operands to the unit
//   Busy, Done, Result         unit status and result
//   AluWE                      ALU owns the write port this cycle
//   WBValid, WBAddr, WBData    multi-cycle writeback (one-cycle pulse)
module mcycle_scheduler #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             ReqValid,
  input  logic             ReqOp,
  input  logic [WIDTH-1:0] ReqOp1,
  input  logic [WIDTH-1:0] ReqOp2,
  input  logic [3:0]       ReqWA3,
  output logic             ReqReady,
  input  logic [3:0]       RA1,
  input  logic [3:0]       RA2,
  input  logic [3:0]       RA3,
  output logic             HazardStall,
  input  logic             Flush,
  output logic             Start,
  output logic             MCycleOp,
  output logic [WIDTH-1:0] Operand1,
  output logic [WIDTH-1:0] Operand2,
  input  logic             Busy,
  input  logic             Done,
  input  logic [WIDTH-1:0] Result,
  input  logic             AluWE,
  output logic             WBValid,
  output logic [3:0]       WBAddr,
  output logic [WIDTH-1:0] WBData
);

  localparam int unsigned AW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_pending;
  logic             r_discard;
  logic             r_start;
  logic             r_wb_valid;
  logic             r_mop;
  logic [WIDTH-1:0] r_opnd1;
  logic [WIDTH-1:0] r_opnd2;
  logic [AW-1:0]    r_wa3;
  logic [WIDTH-1:0] r_buf;
  logic [AW-1:0]    r_wb_addr;
  logic [WIDTH-1:0] r_wb_data;

  state_t           w_state_nxt;
  logic             w_pending_nxt;
  logic             w_discard_nxt;
  logic             w_start_nxt;
  logic             w_wb_nxt;
  logic             w_accept;
  logic             w_bypass;
  logic             w_capture;
  logic [WIDTH-1:0] w_wb_data_nxt;

  // Control state register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_discard  <= 1'b0;
      r_start    <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_discard  <= w_discard_nxt;
      r_start    <= w_start_nxt;
      r_wb_valid <= w_wb_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_discard_nxt = r_discard;
    w_start_nxt   = 1'b0;
    w_wb_nxt      = 1'b0;
    w_accept      = 1'b0;
    w_bypass      = 1'b0;
    w_capture     = 1'b0;
    w_wb_data_nxt = r_buf;

    unique case (r_state)
      S_IDLE: begin
        // A flush in the same cycle suppresses the accept
        if (ReqValid && !Flush) begin
          w_accept      = 1'b1;
          w_pending_nxt = 1'b1;
          w_discard_nxt = 1'b0;
          // Divide by zero never reaches the unit; result is all-ones
          if (ReqOp && (ReqOp2 == '0)) begin
            w_bypass    = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // Flushed ops are still issued; only their writeback is dropped
        if (Flush) begin
          w_discard_nxt = 1'b1;
          w_pending_nxt = 1'b0;
        end
        if (!Busy) begin
          w_start_nxt = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (Flush) begin
          w_discard_nxt = 1'b1;
          w_pending_nxt = 1'b0;
        end
        if (Done) begin
          if (r_discard || Flush) begin
            w_discard_nxt = 1'b0;
            w_pending_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_capture     = 1'b1;
            w_wb_data_nxt = Result;
            if (!AluWE) begin
              w_wb_nxt      = 1'b1;
              w_pending_nxt = 1'b0;
              w_state_nxt   = S_IDLE;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (Flush) begin
          w_pending_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else if (!AluWE) begin
          w_wb_nxt      = 1'b1;
          w_pending_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, result buffer and writeback registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_mop     <= 1'b0;
      r_opnd1   <= '0;
      r_opnd2   <= '0;
      r_wa3     <= '0;
      r_buf     <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_accept) begin
        r_mop   <= ReqOp;
        r_opnd1 <= ReqOp1;
        r_opnd2 <= ReqOp2;
        r_wa3   <= ReqWA3;
      end
      if (w_bypass) begin
        r_buf <= '1;
      end else if (w_capture) begin
        r_buf <= Result;
      end
      if (w_wb_nxt) begin
        r_wb_addr <= r_wa3;
        r_wb_data <= w_wb_data_nxt;
      end
    end
  end

  assign ReqReady    = (r_state == S_IDLE);
  assign HazardStall = r_pending && ((RA1 == r_wa3) || (RA2 == r_wa3) || (RA3 == r_wa3));
  assign Start       = r_start;
  assign MCycleOp    = r_mop;
  assign Operand1    = r_opnd1;
  assign Operand2    = r_opnd2;
  assign WBValid     = r_wb_valid;
  assign WBAddr      = r_wb_addr;
  assign WBData      = r_wb_data;

endmodule

// File: tb/tb_mcycle_scheduler.sv
// Bench for mcycle_scheduler: a behavioural multi-cycle unit stub, a
// writeback scoreboard fed at request time, and directed/random op tests.
module tb_mcycle_scheduler;

  localparam int unsigned WIDTH = 32;
  localparam int          LAT   = 3;

  logic             CLK = 1'b0;
  logic             Reset = 1'b1;
  logic             ReqValid = 1'b0;
  logic             ReqOp = 1'b0;
  logic [WIDTH-1:0] ReqOp1 = '0;
  logic [WIDTH-1:0] ReqOp2 = '0;
  logic [3:0]       ReqWA3 = '0;
  logic             ReqReady;
  logic [3:0]       RA1 = '0;
  logic [3:0]       RA2 = '0;
  logic [3:0]       RA3 = '0;
  logic             HazardStall;
  logic             Flush = 1'b0;
  logic             Start;
  logic             MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic             Busy = 1'b0;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             AluWE = 1'b0;
  logic             WBValid;
  logic [3:0]       WBAddr;
  logic [WIDTH-1:0] WBData;

  mcycle_scheduler #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqOp(ReqOp),
    .ReqOp1(ReqOp1), .ReqOp2(ReqOp2), .ReqWA3(ReqWA3), .ReqReady(ReqReady),
    .RA1(RA1), .RA2(RA2), .RA3(RA3), .HazardStall(HazardStall), .Flush(Flush),
    .Start(Start), .MCycleOp(MCycleOp), .Operand1(Operand1), .Operand2(Operand2),
    .Busy(Busy), .Done(Done), .Result(Result), .AluWE(AluWE),
    .WBValid(WBValid), .WBAddr(WBAddr), .WBData(WBData)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cnt = 0;

  typedef struct {
    logic [3:0]       addr;
    logic [WIDTH-1:0] data;
  } wb_exp_t;
  wb_exp_t sb[$];
  logic [3:0]       last_wb_addr = '0;
  logic [WIDTH-1:0] last_wb_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    if (!op) return a * b;
    if (b == '0) return '1;
    return a / b;
  endfunction

  // Multi-cycle unit stub: Done appears LAT cycles after the Start cycle
  logic             unit_done = 1'b0;
  logic [WIDTH-1:0] unit_res = '0;
  logic             stray_done = 1'b0;
  logic [WIDTH-1:0] stray_res = '0;
  int               ucnt = 0;
  logic             us_seen, us_op;
  logic [WIDTH-1:0] ua, ub;

  assign Done   = unit_done | stray_done;
  assign Result = stray_done ? stray_res : unit_res;

  initial forever begin
    @(negedge CLK);
    us_seen = Start;
    us_op   = MCycleOp;
    ua      = Operand1;
    ub      = Operand2;
    @(posedge CLK);
    #1;
    unit_done = 1'b0;
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) begin
        unit_done = 1'b1;
        Busy      = 1'b0;
      end
    end
    if (us_seen) begin
      ucnt     = LAT - 1;
      Busy     = 1'b1;
      unit_res = model(us_op, ua, ub);
    end
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Writeback scoreboard and start monitor
  initial forever begin
    wb_exp_t e;
    @(negedge CLK);
    if (Start) begin
      start_cnt++;
      check_eq("start_while_busy", 32'(Busy), 32'd0);
    end
    if (WBValid) begin
      last_wb_addr = WBAddr;
      last_wb_data = WBData;
      check_eq("wb_with_alu_we", 32'(AluWE), 32'd0);
      if (sb.size() == 0) begin
        check_eq("wb_unexpected", 32'(WBValid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wb_addr", 32'(WBAddr), 32'(e.addr));
        check_eq("wb_data", 32'(WBData), 32'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_req(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [3:0] wa3);
    ReqValid = 1'b1;
    ReqOp    = op;
    ReqOp1   = a;
    ReqOp2   = b;
    ReqWA3   = wa3;
    RA1      = 4'(wa3 + 4'd1);
    RA2      = wa3;
    RA3      = 4'(wa3 + 4'd2);
  endtask

  // One accepted op; AluWE held high for 'hold' cycles starting at Done
  task automatic run_op(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [3:0] wa3, input int hold, input int lat_exp,
                        input string tag);
    int   c0, s0, wb_cyc;
    logic bypass;
    tick();
    c0     = cyc;
    s0     = start_cnt;
    bypass = op && (b == '0);
    drive_req(op, a, b, wa3);
    sb.push_back('{addr: wa3, data: model(op, a, b)});
    @(negedge CLK);
    check_eq({tag, "_req_ready"}, 32'(ReqReady), 32'd1);
    tick();
    ReqValid = 1'b0;
    wb_cyc   = -1;
    for (int k = 0; k < 40; k++) begin
      AluWE = (hold > 0) && (cyc >= c0 + LAT + 2) && (cyc < c0 + LAT + 2 + hold);
      @(negedge CLK);
      if (WBValid) begin
        wb_cyc = cyc;
        check_eq({tag, "_hazard_at_wb"}, 32'(HazardStall), 32'd0);
        break;
      end
      check_eq({tag, "_hazard"}, 32'(HazardStall), 32'd1);
      check_eq({tag, "_ready_busy"}, 32'(ReqReady), 32'd0);
      if (!bypass && cyc == c0 + LAT + 2)
        check_eq({tag, "_unit_done"}, 32'(Done), 32'd1);
      tick();
    end
    check_eq({tag, "_latency"}, 32'(wb_cyc - c0), 32'(lat_exp));
    check_eq({tag, "_starts"}, 32'(start_cnt - s0), bypass ? 32'd0 : 32'd1);
    tick();
    AluWE = 1'b0;
    @(negedge CLK);
    check_eq({tag, "_wb_pulse"}, 32'(WBValid), 32'd0);
    check_eq({tag, "_ready_after"}, 32'(ReqReady), 32'd1);
    check_eq({tag, "_hazard_after"}, 32'(HazardStall), 32'd0);
  endtask

  initial begin
    int c0;
    int s0;
    logic op;
    logic [WIDTH-1:0] a, b;
    logic [3:0] wa;
    int hold;

    // Reset values
    repeat (3) tick();
    @(negedge CLK);
    check_eq("rst_ready", 32'(ReqReady), 32'd1);
    check_eq("rst_start", 32'(Start), 32'd0);
    check_eq("rst_wbvalid", 32'(WBValid), 32'd0);
    check_eq("rst_wbaddr", 32'(WBAddr), 32'd0);
    check_eq("rst_wbdata", WBData, 32'd0);
    check_eq("rst_operand1", Operand1, 32'd0);
    check_eq("rst_operand2", Operand2, 32'd0);
    check_eq("rst_hazard", 32'(HazardStall), 32'd0);
    tick();
    Reset = 1'b0;

    // MUL 7*6 -> 42 at r4, latency LAT+3
    run_op(1'b0, 32'd7, 32'd6, 4'd4, 0, LAT + 3, "mul7x6");
    check_eq("mul7x6_addr", 32'(last_wb_addr), 32'd4);
    check_eq("mul7x6_data", last_wb_data, 32'd42);

    // DIV 100/0 -> all-ones, two cycles after accept, no Start
    run_op(1'b1, 32'd100, 32'd0, 4'd2, 0, 2, "div100by0");
    check_eq("div0_data", last_wb_data, 32'hFFFF_FFFF);

    // DIV 100/7 with ALU owning the port for three cycles from Done
    run_op(1'b1, 32'd100, 32'd7, 4'd5, 3, LAT + 6, "div100by7");
    check_eq("div7_addr", 32'(last_wb_addr), 32'd5);
    check_eq("div7_data", last_wb_data, 32'd14);

    // Flush during WAIT: no writeback, idle once Done returns
    tick();
    c0 = cyc;
    drive_req(1'b0, 32'd3, 32'd5, 4'd6);
    tick();
    ReqValid = 1'b0;
    for (int k = 1; k <= LAT + 5; k++) begin
      Flush = (cyc == c0 + 3);
      @(negedge CLK);
      check_eq("flush_wait_wb", 32'(WBValid), 32'd0);
      if (cyc == c0 + 4) begin
        check_eq("flush_wait_hazard", 32'(HazardStall), 32'd0);
        check_eq("flush_wait_ready", 32'(ReqReady), 32'd0);
      end
      if (cyc == c0 + LAT + 3) begin
        check_eq("flush_done_ready", 32'(ReqReady), 32'd1);
        check_eq("flush_done_hazard", 32'(HazardStall), 32'd0);
      end
      tick();
    end
    Flush = 1'b0;

    // Reset in WAIT followed by a stray Done
    c0 = cyc;
    drive_req(1'b0, 32'd9, 32'd9, 4'd7);
    tick();
    ReqValid = 1'b0;
    stray_res = 32'hDEAD_BEEF;
    for (int k = 1; k <= LAT + 6; k++) begin
      Reset      = (cyc == c0 + 3);
      stray_done = (cyc == c0 + 4);
      @(negedge CLK);
      check_eq("rst_mid_wb", 32'(WBValid), 32'd0);
      if (cyc >= c0 + 4) begin
        check_eq("rst_mid_ready", 32'(ReqReady), 32'd1);
        check_eq("rst_mid_hazard", 32'(HazardStall), 32'd0);
      end
      tick();
    end
    Reset      = 1'b0;
    stray_done = 1'b0;

    // Flush in HOLD: bypass div held off by the ALU, then flushed
    c0 = cyc;
    drive_req(1'b1, 32'd50, 32'd0, 4'd3);
    AluWE = 1'b1;
    tick();
    ReqValid = 1'b0;
    @(negedge CLK);
    check_eq("hold_hazard", 32'(HazardStall), 32'd1);
    check_eq("hold_ready", 32'(ReqReady), 32'd0);
    tick();
    Flush = 1'b1;
    @(negedge CLK);
    check_eq("hold_flush_wb", 32'(WBValid), 32'd0);
    tick();
    Flush = 1'b0;
    AluWE = 1'b0;
    @(negedge CLK);
    check_eq("hold_flush_ready", 32'(ReqReady), 32'd1);
    check_eq("hold_flush_hazard", 32'(HazardStall), 32'd0);
    check_eq("hold_flush_wb2", 32'(WBValid), 32'd0);
    tick();
    @(negedge CLK);
    check_eq("hold_flush_wb3", 32'(WBValid), 32'd0);

    // Flush in IDLE blocks the accept
    tick();
    s0 = start_cnt;
    drive_req(1'b0, 32'd2, 32'd2, 4'd9);
    Flush = 1'b1;
    tick();
    ReqValid = 1'b0;
    Flush    = 1'b0;
    @(negedge CLK);
    check_eq("idle_flush_ready", 32'(ReqReady), 32'd1);
    check_eq("idle_flush_hazard", 32'(HazardStall), 32'd0);
    repeat (3) tick();
    @(negedge CLK);
    check_eq("idle_flush_nostart", 32'(start_cnt - s0), 32'd0);

    // Random mix of multiplies and divides
    for (int i = 0; i < 8; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = op ? 32'($urandom_range(0, 20)) : $urandom;
      wa = 4'($urandom_range(0, 15));
      if (op && b == '0) begin
        run_op(op, a, b, wa, 0, 2, "rand_bypass");
      end else begin
        hold = $urandom_range(0, 2);
        run_op(op, a, b, wa, hold, LAT + 3 + hold, "rand_op");
      end
    end

    repeat (4) tick();
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
